// File: rtl/pipe_front_regs_if.sv
// Front-end pipeline register bundle: hazard controls, fetch/decode inputs and
// the registered F/D/E-stage outputs plus performance and error status.
interface pipe_front_regs_if #(
  parameter int unsigned CW    = 10,
  parameter int unsigned CNT_W = 16
);
  // Hazard-unit and branch controls
  logic          StallF;
  logic          StallD;
  logic          FlushE;
  logic          PCSrcD;

  // Fetch-stage inputs
  logic [31:0]   PCNextF;
  logic [31:0]   InstrF;
  logic [31:0]   PCPlus4F;

  // Decode-stage inputs
  logic [31:0]   RD1D;
  logic [31:0]   RD2D;
  logic [31:0]   SignImmD;
  logic [4:0]    RsD;
  logic [4:0]    RtD;
  logic [4:0]    RdD;
  logic [CW-1:0] CtrlD;

  // Registered stage outputs
  logic [31:0]   PCF;
  logic [31:0]   InstrD;
  logic [31:0]   PCPlus4D;
  logic          ValidD;
  logic [31:0]   RD1E;
  logic [31:0]   RD2E;
  logic [31:0]   SignImmE;
  logic [4:0]    RsE;
  logic [4:0]    RtE;
  logic [4:0]    RdE;
  logic [CW-1:0] CtrlE;
  logic          ValidE;

  // Status
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;
  logic             ProtoErr;

  modport master (
    output StallF, StallD, FlushE, PCSrcD,
    output PCNextF, InstrF, PCPlus4F,
    output RD1D, RD2D, SignImmD, RsD, RtD, RdD, CtrlD,
    input  PCF, InstrD, PCPlus4D, ValidD,
    input  RD1E, RD2E, SignImmE, RsE, RtE, RdE, CtrlE, ValidE,
    input  StallCount, FlushCount, ProtoErr
  );

  modport slave (
    input  StallF, StallD, FlushE, PCSrcD,
    input  PCNextF, InstrF, PCPlus4F,
    input  RD1D, RD2D, SignImmD, RsD, RtD, RdD, CtrlD,
    output PCF, InstrD, PCPlus4D, ValidD,
    output RD1E, RD2E, SignImmE, RsE, RtE, RdE, CtrlE, ValidE,
    output StallCount, FlushCount, ProtoErr
  );
endinterface

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage MIPS pipeline with hold, bubble
// and squash handling, stage valid bits, saturating counters and a sticky error flag.
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CW       = 10,
  parameter int unsigned CNT_W    = 16
) (
  input logic              Clk,
  input logic              Reset_n,
  pipe_front_regs_if.slave bus
);

  logic [31:0]      r_pcf;
  logic [31:0]      r_instr_d;
  logic [31:0]      r_pcplus4_d;
  logic             r_valid_d;
  logic [31:0]      r_rd1_e;
  logic [31:0]      r_rd2_e;
  logic [31:0]      r_signimm_e;
  logic [4:0]       r_rs_e;
  logic [4:0]       r_rt_e;
  logic [4:0]       r_rd_e;
  logic [CW-1:0]    r_ctrl_e;
  logic             r_valid_e;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             r_proto_err;

  logic w_flush_evt;
  logic w_proto_viol;

  // A stall takes priority over a squash, so a stalled branch never counts twice.
  assign w_flush_evt  = bus.FlushE | (bus.PCSrcD & ~bus.StallD);
  // F and D must stall together, and a decode stall must always bubble E.
  assign w_proto_viol = (bus.StallF ^ bus.StallD) | (bus.StallD & ~bus.FlushE);

  // PC register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pcf <= RESET_PC;
    end else if (!bus.StallF) begin
      r_pcf <= bus.PCNextF;
    end
  end

  // IF/ID register: hold on stall, else squash on taken branch, else load
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_instr_d   <= 32'h0;
      r_pcplus4_d <= 32'h0;
      r_valid_d   <= 1'b0;
    end else if (!bus.StallD) begin
      if (bus.PCSrcD) begin
        r_instr_d   <= 32'h0;
        r_pcplus4_d <= 32'h0;
        r_valid_d   <= 1'b0;
      end else begin
        r_instr_d   <= bus.InstrF;
        r_pcplus4_d <= bus.PCPlus4F;
        r_valid_d   <= 1'b1;
      end
    end
  end

  // ID/EX register: never holds; flush inserts an all-zero bubble
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rd1_e     <= 32'h0;
      r_rd2_e     <= 32'h0;
      r_signimm_e <= 32'h0;
      r_rs_e      <= 5'h0;
      r_rt_e      <= 5'h0;
      r_rd_e      <= 5'h0;
      r_ctrl_e    <= CW'(0);
      r_valid_e   <= 1'b0;
    end else if (bus.FlushE) begin
      r_rd1_e     <= 32'h0;
      r_rd2_e     <= 32'h0;
      r_signimm_e <= 32'h0;
      r_rs_e      <= 5'h0;
      r_rt_e      <= 5'h0;
      r_rd_e      <= 5'h0;
      r_ctrl_e    <= CW'(0);
      r_valid_e   <= 1'b0;
    end else begin
      r_rd1_e     <= bus.RD1D;
      r_rd2_e     <= bus.RD2D;
      r_signimm_e <= bus.SignImmD;
      r_rs_e      <= bus.RsD;
      r_rt_e      <= bus.RtD;
      r_rd_e      <= bus.RdD;
      r_ctrl_e    <= bus.CtrlD;
      r_valid_e   <= r_valid_d;
    end
  end

  // Saturating performance counters
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_stall_cnt <= CNT_W'(0);
      r_flush_cnt <= CNT_W'(0);
    end else begin
      if (bus.StallD && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_evt && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky protocol-error flag; informational only
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_proto_err <= 1'b0;
    end else if (w_proto_viol) begin
      r_proto_err <= 1'b1;
    end
  end

  assign bus.PCF        = r_pcf;
  assign bus.InstrD     = r_instr_d;
  assign bus.PCPlus4D   = r_pcplus4_d;
  assign bus.ValidD     = r_valid_d;
  assign bus.RD1E       = r_rd1_e;
  assign bus.RD2E       = r_rd2_e;
  assign bus.SignImmE   = r_signimm_e;
  assign bus.RsE        = r_rs_e;
  assign bus.RtE        = r_rt_e;
  assign bus.RdE        = r_rd_e;
  assign bus.CtrlE      = r_ctrl_e;
  assign bus.ValidE     = r_valid_e;
  assign bus.StallCount = r_stall_cnt;
  assign bus.FlushCount = r_flush_cnt;
  assign bus.ProtoErr   = r_proto_err;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Scoreboard bench for pipe_front_regs: the driver updates a behavioural model and
// queues the expected post-edge state; a monitor pops and compares after each edge.
module tb_pipe_front_regs;

  localparam int unsigned CW      = 10;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] RST_PC  = 32'hBFC0_0000;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;

  pipe_front_regs_if #(.CW(CW), .CNT_W(CNT_W)) bus ();

  pipe_front_regs #(.RESET_PC(RST_PC), .CW(CW), .CNT_W(CNT_W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0]   pcf;
    logic [31:0]   instr_d;
    logic [31:0]   pc4_d;
    logic          vd;
    logic [31:0]   rd1_e;
    logic [31:0]   rd2_e;
    logic [31:0]   imm_e;
    logic [4:0]    rs_e;
    logic [4:0]    rt_e;
    logic [4:0]    rd_e;
    logic [CW-1:0] ctrl_e;
    logic          ve;
    int            stalls;
    int            flushes;
    logic          proto;
  } model_t;

  model_t m;
  model_t exp_q[$];
  model_t mon_e;
  int n_vec = 0;
  int n_err = 0;

  function automatic model_t reset_model();
    model_t r;
    r = '{default: '0};
    r.pcf = RST_PC;
    return r;
  endfunction

  function automatic logic [31:0] sat(input int n);
    return (n > int'(CNT_MAX)) ? 32'(CNT_MAX) : 32'(n);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input model_t e);
    chk("PCF",        bus.PCF,              e.pcf);
    chk("InstrD",     bus.InstrD,           e.instr_d);
    chk("PCPlus4D",   bus.PCPlus4D,         e.pc4_d);
    chk("ValidD",     32'(bus.ValidD),      32'(e.vd));
    chk("RD1E",       bus.RD1E,             e.rd1_e);
    chk("RD2E",       bus.RD2E,             e.rd2_e);
    chk("SignImmE",   bus.SignImmE,         e.imm_e);
    chk("RsE",        32'(bus.RsE),         32'(e.rs_e));
    chk("RtE",        32'(bus.RtE),         32'(e.rt_e));
    chk("RdE",        32'(bus.RdE),         32'(e.rd_e));
    chk("CtrlE",      32'(bus.CtrlE),       32'(e.ctrl_e));
    chk("ValidE",     32'(bus.ValidE),      32'(e.ve));
    chk("StallCount", 32'(bus.StallCount),  sat(e.stalls));
    chk("FlushCount", 32'(bus.FlushCount),  sat(e.flushes));
    chk("ProtoErr",   32'(bus.ProtoErr),    32'(e.proto));
  endtask

  // Drive one cycle of inputs and queue the state expected after the next edge
  task automatic drive_step(input logic sf, input logic sd, input logic fe, input logic br,
                            input logic [31:0] pcn, input logic [31:0] ins);
    model_t n;
    bus.StallF   = sf;
    bus.StallD   = sd;
    bus.FlushE   = fe;
    bus.PCSrcD   = br;
    bus.PCNextF  = pcn;
    bus.InstrF   = ins;
    bus.PCPlus4F = pcn + 32'd4;
    bus.RD1D     = $urandom;
    bus.RD2D     = $urandom;
    bus.SignImmD = $urandom;
    bus.RsD      = 5'($urandom);
    bus.RtD      = 5'($urandom);
    bus.RdD      = 5'($urandom);
    bus.CtrlD    = CW'($urandom);

    n = m;
    if (!sf) n.pcf = pcn;
    if (!sd) begin
      n.instr_d = br ? 32'h0 : ins;
      n.pc4_d   = br ? 32'h0 : pcn + 32'd4;
      n.vd      = !br;
    end
    if (fe) begin
      n.rd1_e = 0; n.rd2_e = 0; n.imm_e = 0;
      n.rs_e = 0; n.rt_e = 0; n.rd_e = 0; n.ctrl_e = 0; n.ve = 0;
    end else begin
      n.rd1_e = bus.RD1D; n.rd2_e = bus.RD2D; n.imm_e = bus.SignImmD;
      n.rs_e = bus.RsD; n.rt_e = bus.RtD; n.rd_e = bus.RdD;
      n.ctrl_e = bus.CtrlD; n.ve = m.vd;
    end
    n.stalls  = m.stalls + (sd ? 1 : 0);
    n.flushes = m.flushes + ((fe || (br && !sd)) ? 1 : 0);
    n.proto   = m.proto || (sf != sd) || (sd && !fe);
    m = n;
    exp_q.push_back(n);
  endtask

  task automatic step(input logic sf, input logic sd, input logic fe, input logic br);
    @(negedge Clk);
    drive_step(sf, sd, fe, br, $urandom, $urandom);
  endtask

  // Legal random cycle: normal flow, optional branch, or a load-use stall
  task automatic step_legal();
    int mode;
    mode = int'($urandom_range(0, 9));
    if (mode < 6) step(1'b0, 1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    else          step(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  // Asynchronous reset pulse inside the low clock phase, checked before any edge
  task automatic mid_reset();
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    chk("rst PCF",        bus.PCF,                RST_PC);
    chk("rst ProtoErr",   32'(bus.ProtoErr),      32'h0);
    chk("rst ValidD",     32'(bus.ValidD),        32'h0);
    chk("rst StallCount", 32'(bus.StallCount),    32'h0);
    m = reset_model();
    #1 Reset_n = 1'b1;
    drive_step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
  endtask

  // Monitor: compare the registered state shortly after each rising edge
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_all(mon_e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    bus.StallF = 0; bus.StallD = 0; bus.FlushE = 0; bus.PCSrcD = 0;
    bus.PCNextF = 0; bus.InstrF = 0; bus.PCPlus4F = 0;
    bus.RD1D = 0; bus.RD2D = 0; bus.SignImmD = 0;
    bus.RsD = 0; bus.RtD = 0; bus.RdD = 0; bus.CtrlD = 0;
    m = reset_model();

    repeat (2) @(negedge Clk);
    check_all(m);
    Reset_n = 1'b1;
    drive_step(1'b0, 1'b0, 1'b0, 1'b0, 32'd4, 32'h8C08_0004);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    mid_reset();
    for (int i = 0; i < 200; i++) step_legal();

    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step_legal();
    mid_reset();

    for (int i = 0; i < (1 << CNT_W) + 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      if (i % 67 == 66) mid_reset();
      else step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge Clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_front_regs.md
Name: pipe_front_regs

Overview:
- Holds the PC register, the IF/ID pipeline register and the ID/EX pipeline register of the 5-stage MIPS pipeline.
- It is the consumer of the hazard unit's StallF, StallD and FlushE outputs, plus the decode-stage branch decision PCSrcD.
- It implements hold, bubble and squash semantics for those signals.
- It also tracks stage valid bits, saturating stall/flush performance counters and a sticky protocol-error flag for illegal stall/flush combinations.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into PCF on reset.
- CW, 10, width of the decode control bundle (RegWrite, MemToReg, MemWrite, ALUControl, ALUSrc, RegDst, ...).
- CNT_W, 16, width of each performance counter.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- StallF  in  1  hold PC.
- StallD  in  1  hold IF/ID.
- FlushE  in  1  bubble ID/EX.
- PCSrcD  in  1  branch taken in decode; squash IF/ID.
- PCNextF  in  32  next PC.
- InstrF  in  32  fetched instruction.
- PCPlus4F  in  32  PCF+4.
- PCF  out  32  current fetch PC.
- InstrD  out  32  decode instruction.
- PCPlus4D  out  32  decode PC+4.
- ValidD  out  1  IF/ID holds a real instruction.
- RD1D, RD2D  in  32  register-file reads.
- SignImmD  in  32  extended immediate.
- RsD, RtD, RdD  in  5  register fields.
- CtrlD  in  CW  decode control bundle.
- RD1E, RD2E, SignImmE  out  32  execute-stage copies.
- RsE, RtE, RdE  out  5  execute-stage register fields.
- CtrlE  out  CW  execute control.
- ValidE  out  1  ID/EX holds a real instruction.
- StallCount  out  CNT_W  cycles with StallD=1.
- FlushCount  out  CNT_W  cycles where a bubble or squash was inserted.
- ProtoErr  out  1  sticky illegal-combination flag.

Behaviour:
- Reset (Reset_n=0, asynchronous, any time including mid-stall):
  - PCF=RESET_PC.
  - InstrD, PCPlus4D, RD1E, RD2E, SignImmE, RsE, RtE, RdE and CtrlE are all 0.
  - ValidD=ValidE=0, StallCount=FlushCount=0, ProtoErr=0.
  - The first rising edge after deassertion performs normal updates.
- PC register: if StallF=0 then PCF<=PCNextF, else hold.
- IF/ID register, priority order:
  - StallD=1: hold all fields and ValidD.
  - else PCSrcD=1: InstrD<=0 (sll $0 nop), PCPlus4D<=0, ValidD<=0.
  - else load InstrF and PCPlus4F, ValidD<=1.
  - A stall beats a branch squash because the branch operands are unresolved while stalled.
- ID/EX register:
  - FlushE=1: all fields <=0, CtrlE<=0 (RegWrite=MemWrite=0, so a harmless bubble), ValidE<=0.
  - else load the D-stage inputs, ValidE<=ValidD.
  - ID/EX never holds.
- Latency: one cycle per stage, with no combinational path from inputs to outputs.
- StallCount: +1 on every edge where StallD=1; saturates at all-ones with no wrap.
- FlushCount: +1 on every edge where FlushE=1 OR (PCSrcD=1 AND StallD=0); counts 1 per cycle even when both apply; saturates.
- ProtoErr is set on any edge where StallF != StallD, or StallD=1 with FlushE=0 (a decode stall must bubble E). Once set it stays at 1 until reset.
- ProtoErr is informational only: register updates still follow the rules above.
- All-zero inputs with no stall or flush propagate zeros. ValidE follows ValidD, so squashed slots remain invalid through E.

Test Plan:
- Reset release with StallF=StallD=FlushE=PCSrcD=0, PCNextF=4, InstrF=32'h8C08_0004 -> after edge 1: PCF=4, InstrD=32'h8C08_0004, ValidD=1. After edge 2: ValidE=1, CtrlE=CtrlD, counters=0.
- Load-use stall: StallF=StallD=FlushE=1 for 1 cycle with InstrD=X -> PCF and InstrD unchanged, CtrlE=0, ValidE=0, StallCount=1, FlushCount=1, ProtoErr=0.
- Branch taken: PCSrcD=1, StallD=0 -> InstrD=0, ValidD=0, FlushCount+1. One edge later ValidE=0.
- Simultaneous StallD=1, FlushE=1 and PCSrcD=1 -> IF/ID holds (ValidD unchanged), E is bubbled, FlushCount +1 (not +2).
- Illegal StallF=1 with StallD=0 -> ProtoErr=1 and stays at 1 after the inputs return legal. Reset_n pulsed low mid-cycle -> ProtoErr=0 and PCF=RESET_PC immediately, before the next edge.
- Hold StallD=1 with FlushE=1 for 2^CNT_W+3 cycles (CNT_W=4 build) -> StallCount=4'hF and stays there; no wrap.
